// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, MSB-first payload and even parity,
// one bit per clock, followed by a fixed idle gap. All outputs are registered.
module sync_frame_tx #(
    parameter logic [5:0] SYNC   = 6'b101101,
    parameter int         DATA_W = 8,
    parameter int         GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              x,
    output logic              valid,
    output logic              done
);

    localparam int MAX_A   = (DATA_W > 6) ? DATA_W : 6;
    localparam int CNT_MAX = (GAP > MAX_A) ? GAP : MAX_A;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAPW = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [DATA_W-1:0]   shift_r, shift_s;
    logic                par_r, par_s;
    logic                x_r, x_s;
    logic                valid_r, valid_s;
    logic                done_r, done_s;
    logic                ready_r, ready_s;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        even_parity = ^d;
    endfunction

    // Next-state, datapath and next-output computation; cnt holds the index of the bit being shown.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shift_s = shift_r;
        par_s   = par_r;
        x_s     = 1'b0;
        valid_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SYNC;
                    shift_s = din;
                    par_s   = even_parity(din);
                    cnt_s   = CNT_W'(5);
                    x_s     = SYNC[5];
                    valid_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                valid_s = 1'b1;
                if (cnt_r != '0) begin
                    cnt_s = cnt_r - CNT_W'(1);
                    x_s   = |(SYNC & (6'b000001 << cnt_s));
                end else begin
                    state_s = ST_DATA;
                    cnt_s   = CNT_W'(DATA_W - 1);
                    x_s     = shift_r[DATA_W-1];
                end
            end
            ST_DATA: begin
                valid_s = 1'b1;
                if (cnt_r != '0) begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    shift_s = shift_r << 1;
                    x_s     = shift_s[DATA_W-1];
                end else begin
                    state_s = ST_PAR;
                    cnt_s   = '0;
                    x_s     = par_r;
                end
            end
            ST_PAR: begin
                state_s = ST_GAPW;
                cnt_s   = CNT_W'(GAP - 1);
                done_s  = 1'b1;
            end
            ST_GAPW: begin
                if (cnt_r != '0) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            shift_r <= '0;
            par_r   <= 1'b0;
            x_r     <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            x_r     <= x_s;
            valid_r <= valid_s;
            done_r  <= done_s;
            ready_r <= ready_s;
        end
    end

    assign x     = x_r;
    assign valid = valid_r;
    assign done  = done_r;
    assign ready = ready_r;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed and random self-checking bench for sync_frame_tx at default parameters.
module tb_sync_frame_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       ready;
    logic       x;
    logic       valid;
    logic       done;

    int checks = 0;
    int errors = 0;

    sync_frame_tx dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .ready (ready),
        .x     (x),
        .valid (valid),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout, expected end of run");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Deserialize one frame; optionally drive start/din mid-frame at bit poke_at.
    task automatic collect(output logic [14:0] w, input int poke_at, input logic [7:0] poke_din);
        int n;
        n = 0;
        w = '0;
        while (!valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start", 32'(valid), 32'd1);
        for (int i = 0; i < 15; i++) begin
            chk("valid_in_frame", 32'(valid), 32'd1);
            chk("done_in_frame", 32'(done), 32'd0);
            chk("ready_in_frame", 32'(ready), 32'd0);
            w = {w[13:0], x};
            if (i == poke_at) begin
                start = 1'b1;
                din   = poke_din;
            end else if (poke_at >= 0 && i == poke_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("valid_after_frame", 32'(valid), 32'd0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_return", 32'(ready), 32'd1);
    endtask

    task automatic pulse(input logic [7:0] d);
        start = 1'b1;
        din   = d;
        @(negedge clk);
        start = 1'b0;
        din   = ~d;
    endtask

    initial begin
        logic [14:0] w;
        logic [7:0]  d;
        int          cnt;
        int          dcnt;

        rst   = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_ready", 32'(ready), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start_valid", 32'(valid), 32'd0);
        chk("idle_no_start_ready", 32'(ready), 32'd1);

        // A5: full frame, then done and ready timing
        pulse(8'hA5);
        collect(w, -1, 8'h00);
        chk("frame_a5", 32'(w), 32'(15'b101101_10100101_0));
        chk("a5_done", 32'(done), 32'd1);
        chk("a5_ready_gap1", 32'(ready), 32'd0);
        @(negedge clk);
        chk("a5_done_once", 32'(done), 32'd0);
        chk("a5_ready_gap2", 32'(ready), 32'd0);
        chk("a5_valid_gap2", 32'(valid), 32'd0);
        @(negedge clk);
        chk("a5_ready_back", 32'(ready), 32'd1);
        chk("a5_done_idle", 32'(done), 32'd0);

        pulse(8'h01);
        collect(w, -1, 8'h00);
        chk("frame_01", 32'(w), 32'(15'b101101_00000001_1));
        wait_ready();

        pulse(8'h00);
        collect(w, -1, 8'h00);
        chk("frame_00", 32'(w), 32'(15'b101101_00000000_0));
        wait_ready();

        // start held high: back-to-back frames with GAP+1 idle cycles between
        start = 1'b1;
        din   = 8'hFF;
        @(negedge clk);
        collect(w, -1, 8'h00);
        chk("frame_ff_1", 32'(w), 32'(15'b101101_11111111_0));
        cnt = 1;
        while (cnt < 20) begin
            @(negedge clk);
            if (valid) break;
            cnt++;
        end
        chk("b2b_gap", 32'(cnt), 32'd3);
        collect(w, -1, 8'h00);
        start = 1'b0;
        chk("frame_ff_2", 32'(w), 32'(15'b101101_11111111_0));
        wait_ready();
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        chk("b2b_stop", 32'(cnt), 32'd0);

        // start plus new din during DATA is ignored
        pulse(8'h55);
        collect(w, 8, 8'h3C);
        chk("frame_55_poked", 32'(w), 32'(15'b101101_01010101_0));
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        chk("no_second_frame", 32'(cnt), 32'd0);

        // reset at 4th payload bit aborts the frame
        pulse(8'hD5);
        repeat (9) @(negedge clk);
        chk("pre_rst_x", 32'(x), 32'd1);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_x", 32'(x), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cnt  = 0;
        dcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid) cnt++;
            if (done) dcnt++;
        end
        chk("abort_no_valid", 32'(cnt), 32'd0);
        chk("abort_no_done", 32'(dcnt), 32'd0);
        chk("abort_idle_ready", 32'(ready), 32'd1);
        pulse(8'h96);
        collect(w, -1, 8'h00);
        chk("frame_96_fresh", 32'(w), 32'(15'b101101_10010110_0));
        wait_ready();

        // random frames with a deserializing scoreboard
        for (int f = 0; f < 1000; f++) begin
            d = 8'($urandom);
            pulse(d);
            collect(w, -1, 8'h00);
            chk("rnd_sync", 32'(w[14:9]), 32'(6'b101101));
            chk("rnd_payload", 32'(w[8:1]), 32'(d));
            chk("rnd_parity", 32'(^w[8:0]), 32'd0);
            wait_ready();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
